// File: rtl/hpdcache_sram_pkg.sv
// Shared definitions for the hpdcache behavioural SRAM models.
//   RD_LATENCY_MIN/MAX : legal range of the read latency parameter
//   sram_init_state_e  : states of the optional zero-init sequencer
//   sram_nbytes()      : number of bytes in a data word
package hpdcache_sram_pkg;
    localparam int unsigned RD_LATENCY_MIN = 1;
    localparam int unsigned RD_LATENCY_MAX = 4;

    typedef enum logic {
        SRAM_INIT,
        SRAM_RUN
    } sram_init_state_e;

    function automatic int unsigned sram_nbytes(input int unsigned data_size);
        return data_size / 8;
    endfunction
endpackage

// File: rtl/hpdcache_sram_rd_pipe.sv
// Read-result pipeline for the 1RW SRAM model.
// Delays an accepted read (valid + sampled word) by RD_LATENCY-1 register
// stages, then loads the output register that drives rdata/rvalid.
//   clk, rst_n : clock, asynchronous active-low reset
//   vld_i      : read accepted this cycle
//   data_i     : word sampled from the array at accept time
//   rdata_o    : last completed read result (held between reads)
//   rvalid_o   : one-cycle strobe per completed read
module hpdcache_sram_rd_pipe
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned RD_LATENCY = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);
    localparam int unsigned NSTAGE = RD_LATENCY - 1;

    logic              last_v;
    logic [DATA_W-1:0] last_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    generate
        if (NSTAGE == 0) begin : g_direct
            assign last_v = vld_i;
            assign last_d = data_i;
        end else begin : g_pipe
            logic [NSTAGE-1:0] v_q;
            logic [DATA_W-1:0] d_q [NSTAGE];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= vld_i;
                    for (int unsigned i = 1; i < NSTAGE; i++) begin
                        v_q[i] <= v_q[i-1];
                    end
                end
            end

            // Data stages need no reset: they are only observed when the
            // matching valid bit is set.
            always_ff @(posedge clk) begin
                d_q[0] <= data_i;
                for (int unsigned i = 1; i < NSTAGE; i++) begin
                    d_q[i] <= d_q[i-1];
                end
            end

            assign last_v = v_q[NSTAGE-1];
            assign last_d = d_q[NSTAGE-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= last_v;
            if (last_v) begin
                rdata_q <= last_d;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
endmodule

// File: rtl/hpdcache_sram_wbe_1rw_pipe.sv
// Behavioural single-port SRAM with per-byte write enables, configurable
// read latency (rvalid strobe), a ready output and defined out-of-range
// behaviour (writes dropped, reads return zero).
//   clk, rst_n : clock, asynchronous active-low reset
//   cs, we     : request valid, 1 = write / 0 = read
//   addr       : entry index
//   wbe, wdata : byte enables and write data, [NDATA][bytes] / [NDATA][bits]
//   rdata      : read result, held until the next read completes
//   rvalid     : one-cycle strobe per completed read
//   ready      : requests are accepted
// Optional macro HPDCACHE_SRAM_ZERO_INIT_EN: after reset, zero every entry
// (one per cycle, DEPTH cycles) with ready low, then run.
module hpdcache_sram_wbe_1rw_pipe
    import hpdcache_sram_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 6,
    parameter int unsigned DATA_SIZE  = 64,
    parameter int unsigned DEPTH      = 2**ADDR_SIZE,
    parameter int unsigned NDATA      = 1,
    parameter int unsigned RD_LATENCY = 1
)(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cs,
    input  logic                                   we,
    input  logic [ADDR_SIZE-1:0]                   addr,
    input  logic [NDATA*sram_nbytes(DATA_SIZE)-1:0] wbe,
    input  logic [NDATA*DATA_SIZE-1:0]             wdata,
    output logic [NDATA*DATA_SIZE-1:0]             rdata,
    output logic                                   rvalid,
    output logic                                   ready
);
    localparam int unsigned WORD_W = NDATA * DATA_SIZE;
    localparam int unsigned NBYTES = NDATA * sram_nbytes(DATA_SIZE);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
            $error("RD_LATENCY out of range 1..4");
        end
        if (DATA_SIZE % 8 != 0) begin : g_bad_data_size
            $error("DATA_SIZE must be a multiple of 8");
        end
        if (DEPTH < 1 || DEPTH > 2**ADDR_SIZE) begin : g_bad_depth
            $error("DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_SIZE");
        end
    endgenerate

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              req_acc;
    logic              in_range;
    logic              rd_en;
    logic [WORD_W-1:0] rd_word;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [NBYTES-1:0] wr_be;
    logic [WORD_W-1:0] wr_data;

    assign req_acc  = cs & ready;
    assign in_range = 32'(addr) < DEPTH;
    assign rd_en    = req_acc & ~we;
    assign rd_word  = in_range ? mem_q[addr[IDX_W-1:0]] : '0;

`ifdef HPDCACHE_SRAM_ZERO_INIT_EN
    sram_init_state_e     state_q;
    logic [ADDR_SIZE-1:0] cnt_q;
    logic                 ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SRAM_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == SRAM_INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (32'(cnt_q) == DEPTH - 1) begin
                state_q <= SRAM_RUN;
                ready_q <= 1'b1;
            end
        end
    end

    assign ready = ready_q;

    // The init sequencer owns the write port until it reaches RUN; user
    // requests cannot be accepted then because ready is low.
    always_comb begin
        wr_en   = req_acc & we & in_range;
        wr_idx  = addr[IDX_W-1:0];
        wr_be   = wbe;
        wr_data = wdata;
        if (state_q == SRAM_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q[IDX_W-1:0];
            wr_be   = '1;
            wr_data = '0;
        end
    end
`else
    assign ready = 1'b1;

    always_comb begin
        wr_en   = req_acc & we & in_range;
        wr_idx  = addr[IDX_W-1:0];
        wr_be   = wbe;
        wr_data = wdata;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    hpdcache_sram_rd_pipe #(
        .DATA_W     (WORD_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld_i    (rd_en),
        .data_i   (rd_word),
        .rdata_o  (rdata),
        .rvalid_o (rvalid)
    );
endmodule

// File: tb/tb_hpdcache_sram_wbe_1rw_pipe.sv
module tb_hpdcache_sram_wbe_1rw_pipe;
    localparam int AW  = 6;
    localparam int DW  = 64;
    localparam int RDL = 3;
`ifdef HPDCACHE_SRAM_ZERO_INIT_EN
    localparam int DEP = 16;
`else
    localparam int DEP = 48;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs    = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [7:0]    wbe   = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          ready;

    hpdcache_sram_wbe_1rw_pipe #(
        .ADDR_SIZE  (AW),
        .DATA_SIZE  (DW),
        .DEPTH      (DEP),
        .NDATA      (1),
        .RD_LATENCY (RDL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs     (cs),
        .we     (we),
        .addr   (addr),
        .wbe    (wbe),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          is_wr;
        logic [5:0]  a;
        logic [7:0]  m;
        logic [63:0] d;   // write data, or expected read data
        string       name;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] m, input logic [63:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wbe = m; wdata = d;
        tick();
        cs = 1'b0; we = 1'b0; wbe = '0; wdata = '0;
    endtask

    // Issue one read and check the full response window: no rvalid before
    // the latency expires, one pulse with the data, then rdata held.
    task automatic rd(input logic [5:0] a, input logic [63:0] exp, input string name);
        cs = 1'b1; we = 1'b0; addr = a;
        tick();
        cs = 1'b0;
        for (int k = 0; k < RDL - 1; k++) begin
            check({name, "_early_rvalid"}, 64'(rvalid), 64'd0);
            tick();
        end
        check({name, "_rvalid"}, 64'(rvalid), 64'd1);
        check({name, "_rdata"}, rdata, exp);
        tick();
        check({name, "_rvalid_drop"}, 64'(rvalid), 64'd0);
        check({name, "_rdata_hold"}, rdata, exp);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 6'd5,        8'hFF, 64'hDEADBEEF_CAFEF00D, "w5_full"};
        tbl[1]  = '{1'b0, 6'd5,        8'h00, 64'hDEADBEEF_CAFEF00D, "r5_full"};
        tbl[2]  = '{1'b1, 6'd5,        8'h0F, 64'h0,                 "w5_mask"};
        tbl[3]  = '{1'b0, 6'd5,        8'h00, 64'hDEADBEEF_00000000, "r5_mask"};
        tbl[4]  = '{1'b1, 6'd0,        8'hFF, 64'hA0,                "w0"};
        tbl[5]  = '{1'b1, 6'd1,        8'hFF, 64'h11,                "w1"};
        tbl[6]  = '{1'b1, 6'd2,        8'hFF, 64'h22,                "w2"};
        tbl[7]  = '{1'b1, 6'd3,        8'hFF, 64'h33,                "w3"};
        tbl[8]  = '{1'b1, 6'(DEP - 1), 8'hFF, 64'hBB,                "wlast"};
        tbl[9]  = '{1'b1, 6'd50,       8'hFF, 64'hFFFFFFFF_FFFFFFFF, "w50_oor"};
        tbl[10] = '{1'b0, 6'd50,       8'h00, 64'h0,                 "r50_oor"};
        tbl[11] = '{1'b0, 6'd0,        8'h00, 64'hA0,                "r0_after_oor"};
        tbl[12] = '{1'b0, 6'(DEP - 1), 8'h00, 64'hBB,                "rlast_after_oor"};
        tbl[13] = '{1'b1, 6'd3,        8'h02, 64'h00000000_00005500, "w3_byte1"};
        tbl[14] = '{1'b0, 6'd3,        8'h00, 64'h00000000_00005533, "r3_byte1"};
        tbl[15] = '{1'b0, 6'd2,        8'h00, 64'h22,                "r2_after_oor"};
        tbl[16] = '{1'b1, 6'd3,        8'hFF, 64'h33,                "w3_restore"};

        // Reset state
        tick();
        tick();
        check("reset_rdata", rdata, 64'd0);
        check("reset_rvalid", 64'(rvalid), 64'd0);
`ifdef HPDCACHE_SRAM_ZERO_INIT_EN
        check("reset_ready", 64'(ready), 64'd0);
        rst_n = 1'b1;
        // A read requested during init must be ignored.
        cs = 1'b1; we = 1'b0; addr = 6'd1;
        for (int k = 0; k < DEP; k++) begin
            check("init_ready_low", 64'(ready), 64'd0);
            check("init_no_rvalid", 64'(rvalid), 64'd0);
            tick();
        end
        cs = 1'b0;
        check("init_ready_high", 64'(ready), 64'd1);
        check("init_cs_ignored", 64'(rvalid), 64'd0);
        rd(6'd7, 64'd0, "init_zero_r7");
        rd(6'(DEP - 1), 64'd0, "init_zero_rlast");
`else
        check("reset_ready", 64'(ready), 64'd1);
        rst_n = 1'b1;
        tick();
`endif

        // Table-driven writes/reads
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].a, tbl[i].m, tbl[i].d);
                check({tbl[i].name, "_no_rvalid"}, 64'(rvalid), 64'd0);
            end else begin
                rd(tbl[i].a, tbl[i].d, tbl[i].name);
            end
        end

        // Back-to-back reads: 1, 2, 3 on consecutive cycles.
        for (int k = 1; k <= 3; k++) begin
            cs = 1'b1; we = 1'b0; addr = 6'(k);
            tick();
            if (k < 3) check("b2b_early_rvalid", 64'(rvalid), 64'd0);
        end
        cs = 1'b0;
        check("b2b_v1", 64'(rvalid), 64'd1);
        check("b2b_d1", rdata, 64'h11);
        tick();
        check("b2b_v2", 64'(rvalid), 64'd1);
        check("b2b_d2", rdata, 64'h22);
        tick();
        check("b2b_v3", 64'(rvalid), 64'd1);
        check("b2b_d3", rdata, 64'h33);
        tick();
        check("b2b_end_rvalid", 64'(rvalid), 64'd0);
        check("b2b_end_hold", rdata, 64'h33);

        // Read of addr 2 followed next cycle by a write to addr 2.
        cs = 1'b1; we = 1'b0; addr = 6'd2;
        tick();
        we = 1'b1; wbe = 8'hFF; wdata = 64'h99;
        tick();
        cs = 1'b0; we = 1'b0; wbe = '0; wdata = '0;
        check("inflight_early_rvalid", 64'(rvalid), 64'd0);
        tick();
        check("inflight_rvalid", 64'(rvalid), 64'd1);
        check("inflight_rdata_old", rdata, 64'h22);
        tick();
        rd(6'd2, 64'h99, "r2_new");

        // Reset while a read is in flight.
        cs = 1'b1; we = 1'b0; addr = 6'd1;
        tick();
        cs = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", 64'(rvalid), 64'd0);
        check("midrst_rdata", rdata, 64'd0);
        tick();
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
`ifdef HPDCACHE_SRAM_ZERO_INIT_EN
            for (int k = 0; k < DEP + RDL + 2; k++) begin
`else
            for (int k = 0; k < RDL + 2; k++) begin
`endif
                if (rvalid) seen++;
                tick();
            end
            check("midrst_no_rvalid_after", 64'(seen), 64'd0);
        end
        check("midrst_ready", 64'(ready), 64'd1);
`ifdef HPDCACHE_SRAM_ZERO_INIT_EN
        rd(6'd5, 64'd0, "reinit_zero_r5");
`else
        rd(6'd1, 64'h11, "midrst_mem_kept_r1");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
